// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: 2-flop input synchronizer, mid-bit sampling
// from a shared baud counter, one-cycle rx_valid / frame_err pulses.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] LIM_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] LIM_BIT  = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  localparam logic [2:0] HOLD  = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic [2:0]    state;
  logic          sync_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_lim;
  logic          sample;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // START waits half a bit so every later sample lands mid-bit.
  assign cnt_lim = (state == START) ? LIM_HALF : LIM_BIT;
  assign sample  = (cnt == cnt_lim);
  assign rx_busy = (state == START) || (state == DATA) || (state == STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
      state     <= HOLD;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_meta <= rx_in;
      rx_s      <= sync_meta;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (rx_busy) begin
        cnt <= sample ? '0 : cnt + CW'(1);
      end

      case (state)
        HOLD: begin
          if (rx_s) state <= IDLE;
        end
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (sample) begin
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (sample) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            // A low stop bit drops into HOLD so a stuck-low line cannot start a frame.
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
